// File: rtl/sc1_pkg.sv
// Shared types for the program loader: FSM encoding, header length, per-state status decode.
package sc1_pkg;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        CSUM,
        FLUSH,
        RUN,
        ERR
    } state_t;

    // Header is a little-endian 16-bit word count.
    localparam int HDR_BYTES = 2;

    typedef struct packed {
        logic in_ready;
        logic busy;
        logic cpu_reset;
        logic error;
    } status_t;

    function automatic status_t status_of(state_t s);
        status_t st;
        st.in_ready  = (s != FLUSH) && (s != RUN);
        st.busy      = (s != RUN) && (s != ERR);
        st.cpu_reset = (s != RUN);
        st.error     = (s == ERR);
        return st;
    endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word with a one-cycle word_valid strobe.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] low_bytes;
    logic [1:0]  count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            low_bytes  <= '0;
            count      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            low_bytes  <= '0;
            count      <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                count <= count + 2'd1;
                if (count == 2'd3) begin
                    word       <= {byte_in, low_bytes};
                    word_valid <= 1'b1;
                end else begin
                    // First byte shifts down to bits 7:0 by the time the word completes.
                    low_bytes <= {byte_in, low_bytes[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed program into instruction RAM, then releases the CPU from reset.
// Optional trailing checksum byte is enabled with macro PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import sc1_pkg::*;
#(
    parameter int DEPTH_I = 8,
    parameter int WIDTH_I = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               reload,
    output logic [DEPTH_I-1:0] ram_addr,
    output logic [WIDTH_I-1:0] ram_data,
    output logic               ram_we,
    output logic               cpu_reset,
    output logic               busy,
    output logic               error
);

    localparam int HDR_BITS = 8 * HDR_BYTES;
    localparam logic [HDR_BITS:0] MAX_WORDS = (HDR_BITS + 1)'(2 ** DEPTH_I);
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = FLUSH;
`endif

    state_t                state;
    state_t                nxt;
    logic [7:0]            count_lo;
    logic [HDR_BITS-1:0]   word_count;
    logic [HDR_BITS+1:0]   bytes_left;
    logic                  accept;
    logic                  data_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    // reload wins over a coinciding handshake, so that byte never lands anywhere.
    assign accept     = in_valid && in_ready && !reload;
    assign data_byte  = accept && (state == DATA);
    assign word_count = {in_data, count_lo};

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (reload),
        .byte_in    (in_data),
        .byte_valid (data_byte),
        .word       (ram_data),
        .word_valid (ram_we)
    );

    // NOTE: nxt gets a default first so no path through the case can infer a latch.
    always_comb begin
        nxt = state;
        if (reload) begin
            nxt = HDR0;
        end else begin
            case (state)
                HDR0: if (accept) nxt = HDR1;
                HDR1: begin
                    if (accept) begin
                        if ({1'b0, word_count} > MAX_WORDS) nxt = ERR;
                        else if (word_count == '0)          nxt = AFTER_DATA;
                        else                                nxt = DATA;
                    end
                end
                DATA: if (accept && bytes_left == (HDR_BITS + 2)'(1)) nxt = AFTER_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
                CSUM: if (accept) nxt = (in_data == csum) ? FLUSH : ERR;
`endif
                FLUSH:   nxt = RUN;
                default: nxt = state;
            endcase
        end
    end

    // Status outputs are decoded from the next state so they change with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                              <= HDR0;
            {in_ready, busy, cpu_reset, error} <= status_of(HDR0);
            count_lo                           <= '0;
            bytes_left                         <= '0;
            ram_addr                           <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum                               <= '0;
`endif
        end else begin
            state                              <= nxt;
            {in_ready, busy, cpu_reset, error} <= status_of(nxt);
            if (reload) begin
                count_lo   <= '0;
                bytes_left <= '0;
                ram_addr   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum       <= '0;
`endif
            end else begin
                if (accept && state == HDR0) count_lo <= in_data;
                if (accept && state == HDR1) bytes_left <= {word_count, 2'b00};
                if (data_byte) begin
                    bytes_left <= bytes_left - (HDR_BITS + 2)'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum       <= csum + in_data;
`endif
                end
                // Advance after each write but park on the top address of a full RAM.
                if (ram_we && ram_addr != '1) ram_addr <= ram_addr + DEPTH_I'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: expected RAM writes are queued, a monitor pops and compares them.
`timescale 1ns/1ps
module tb_prog_loader;

    localparam int DEPTH_I = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               reload;
    logic [DEPTH_I-1:0] ram_addr;
    logic [31:0]        ram_data;
    logic               ram_we;
    logic               cpu_reset;
    logic               busy;
    logic               error;

    int tests    = 0;
    int fails    = 0;
    int we_count = 0;
    logic [7:0] sum;

    typedef struct {
        logic [DEPTH_I-1:0] addr;
        logic [31:0]        data;
    } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    prog_loader #(.DEPTH_I(DEPTH_I), .WIDTH_I(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reload    (reload),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_we    (ram_we),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .error     (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected-write queue.
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (ram_we === 1'b1) begin
                we_count++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, no write expected", ram_addr, ram_data);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(ram_addr), 32'(e.addr));
                    check("write_data", ram_data, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        if (in_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: in_ready stayed %b, expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_header(input logic [15:0] n);
        sum = 8'h00;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            send_byte(w[8*i +: 8]);
            sum = sum + w[8*i +: 8];
        end
    endtask

    task automatic send_csum();
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(sum);
`endif
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    // Called right after the final byte's accepting edge: one FLUSH cycle, then RUN.
    task automatic expect_run(input string name);
        check({name, "_flush_cpu_reset"}, 32'(cpu_reset), 32'd1);
        tick();
        check({name, "_run_cpu_reset"}, 32'(cpu_reset), 32'd0);
        check({name, "_run_busy"}, 32'(busy), 32'd0);
        check({name, "_run_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin : stimulus
        int wc;
        logic [31:0] w;

        reset    = 1'b1;
        reload   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        sum      = 8'h00;
        repeat (3) tick();
        check("reset_cpu_reset", 32'(cpu_reset), 32'd1);
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_error", 32'(error), 32'd0);
        check("reset_ram_we", 32'(ram_we), 32'd0);
        check("reset_ram_addr", 32'(ram_addr), 32'd0);
        check("reset_ram_data", ram_data, 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        tick();

        // Two-word load, back to back.
        exp_q.push_back('{addr: 8'h00, data: 32'h12345678});
        exp_q.push_back('{addr: 8'h01, data: 32'hDEADBEEF});
        send_header(16'd2);
        send_word(32'h12345678, 0);
        send_word(32'hDEADBEEF, 0);
        send_csum();
        expect_run("two_word");
        check("two_word_writes", 32'(we_count), 32'd2);

        do_reload();
        check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        check("reload_busy", 32'(busy), 32'd1);

        // Empty program.
        wc = we_count;
        send_header(16'd0);
        send_csum();
        expect_run("empty");
        check("empty_no_writes", 32'(we_count), 32'(wc));

        // Oversized program goes to ERR and drains bytes.
        do_reload();
        wc = we_count;
        send_header(16'd257);
        check("oversize_error", 32'(error), 32'd1);
        check("oversize_cpu_reset", 32'(cpu_reset), 32'd1);
        check("oversize_busy", 32'(busy), 32'd0);
        send_byte(8'h11);
        send_byte(8'h22);
        check("err_drain_error", 32'(error), 32'd1);
        check("err_drain_in_ready", 32'(in_ready), 32'd1);
        check("oversize_no_writes", 32'(we_count), 32'(wc));

        // Full RAM: last write at top address, no wrap afterwards.
        do_reload();
        check("reload_clears_error", 32'(error), 32'd0);
        send_header(16'd256);
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), ~8'(i), 8'hA5, 8'(i) ^ 8'h3C};
            exp_q.push_back('{addr: 8'(i), data: w});
            send_word(w, 0);
        end
        send_csum();
        expect_run("full");
        check("full_addr_no_wrap", 32'(ram_addr), 32'hFF);

        // Reload part-way through the second word, with a byte offered in the same cycle.
        do_reload();
        exp_q.push_back('{addr: 8'h00, data: 32'h11223344});
        send_header(16'd2);
        send_word(32'h11223344, 0);
        send_byte(8'h55);
        send_byte(8'h66);
        wc       = we_count;
        in_data  = 8'h77;
        in_valid = 1'b1;
        reload   = 1'b1;
        tick();
        reload   = 1'b0;
        in_valid = 1'b0;
        check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (3) tick();
        check("abort_write_suppressed", 32'(we_count), 32'(wc));
        exp_q.push_back('{addr: 8'h00, data: 32'hCAFEF00D});
        send_header(16'd1);
        send_word(32'hCAFEF00D, 0);
        send_csum();
        expect_run("after_abort");

        // Sixteen words with random stalls between bytes.
        do_reload();
        send_header(16'd16);
        for (int i = 0; i < 16; i++) begin
            w = 32'h01020304 * (i + 1) + 32'h0F0F0000;
            exp_q.push_back('{addr: 8'(i), data: w});
            send_word(w, 1);
        end
        send_csum();
        expect_run("gappy");
        for (int i = 0; i < 4; i++) begin
            tick();
            check("run_in_ready_low", 32'(in_ready), 32'd0);
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        do_reload();
        exp_q.push_back('{addr: 8'h00, data: 32'h04030201});
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h0A);
        expect_run("csum_good");

        do_reload();
        exp_q.push_back('{addr: 8'h00, data: 32'h04030201});
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h0B);
        check("csum_bad_error", 32'(error), 32'd1);
        check("csum_bad_cpu_reset", 32'(cpu_reset), 32'd1);
        send_byte(8'h33);
        send_byte(8'h44);
        check("csum_bad_hold_error", 32'(error), 32'd1);
        check("csum_bad_hold_cpu_reset", 32'(cpu_reset), 32'd1);
`endif

        repeat (3) tick();
        check("all_writes_seen", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
